// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: word geometry, FSM states, even/odd interleave.
// Used by both the bit splitter and the bit combiner.
package qpsk_pkg;

  localparam int NSYM_DEFAULT = 4;
  localparam int NSYM_MAX     = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The bit counter must be at least one bit wide, even for a 2-bit word.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  // Fixed maximum width so one function serves every NSYM. Callers
  // zero-extend the nibbles and keep the low 2*NSYM bits.
  function automatic logic [2*NSYM_MAX-1:0] interleave(
    input logic [NSYM_MAX-1:0] even,
    input logic [NSYM_MAX-1:0] odd
  );
    logic [2*NSYM_MAX-1:0] w;
    w = '0;
    for (int k = 0; k < NSYM_MAX; k++) begin
      w[2*k]   = even[k];
      w[2*k+1] = odd[k];
    end
    return w;
  endfunction

endpackage

// File: rtl/qpsk_bit_combiner_if.sv
// Even/odd nibble input handshake plus serial and reassembled-word outputs.
// The slave modport is the combiner's view; master is the source/sink view.
interface qpsk_bit_combiner_if #(
  parameter int NSYM = qpsk_pkg::NSYM_DEFAULT
);

  localparam int W = 2 * NSYM;

  logic            in_valid;
  logic            in_ready;
  logic [NSYM-1:0] Sheve;
  logic [NSYM-1:0] Shodd;
  logic            ser_bit;
  logic            ser_valid;
  logic            ser_odd;
  logic [W-1:0]    byte_out;
  logic            byte_valid;

  modport master (
    output in_valid,
    output Sheve,
    output Shodd,
    input  in_ready,
    input  ser_bit,
    input  ser_valid,
    input  ser_odd,
    input  byte_out,
    input  byte_valid
  );

  modport slave (
    input  in_valid,
    input  Sheve,
    input  Shodd,
    output in_ready,
    output ser_bit,
    output ser_valid,
    output ser_odd,
    output byte_out,
    output byte_valid
  );

endinterface

// File: rtl/qpsk_sipo_word.sv
// Serial-in parallel-out word collector: word/done register on the edge that shifts in the bit flagged last.
// No backpressure; shift_en is a strobe, and word holds until the next completion.
module qpsk_sipo_word #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         din,
  input  logic         last,
  output logic [W-1:0] word,
  output logic         done
);

  logic [W-2:0] acc_q;
  logic [W-1:0] acc_next;

  assign acc_next = {acc_q, din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      word  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (shift_en) begin
        acc_q <= acc_next[W-2:0];
        if (last) begin
          word <= acc_next;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/qpsk_bit_combiner.sv
// Interleaves even/odd nibbles and streams the word MSB first; reassembled word pulses valid W+1 cycles after transfer.
// in_ready is high in IDLE and on the last bit cycle only, which allows bubble-free back-to-back words.
module qpsk_bit_combiner
  import qpsk_pkg::*;
#(
  parameter int NSYM = NSYM_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  qpsk_bit_combiner_if.slave  bus
);

  localparam int             W       = 2 * NSYM;
  localparam int             CW      = cnt_width(W);
  localparam logic [CW-1:0]  CNT_TOP = CW'(W - 1);

  state_t            state_q, state_d;
  logic [W-1:0]      sr_q, sr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              in_ready;
  logic              shifting;
  logic              last_bit;

  logic [NSYM_MAX-1:0]   ev_ext;
  logic [NSYM_MAX-1:0]   od_ext;
  logic [2*NSYM_MAX-1:0] ileave_full;
  logic [W-1:0]          word_in;
  logic                  unused_ileave;

  always_comb begin
    ev_ext          = '0;
    od_ext          = '0;
    ev_ext[NSYM-1:0] = bus.Sheve;
    od_ext[NSYM-1:0] = bus.Shodd;
  end

  assign ileave_full   = interleave(ev_ext, od_ext);
  assign word_in       = ileave_full[W-1:0];
  assign unused_ileave = ^(ileave_full >> W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          sr_d    = word_in;
          cnt_d   = CNT_TOP;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {sr_q[W-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          // Last bit cycle: a new word can be taken without a gap.
          in_ready = 1'b1;
          if (bus.in_valid) begin
            sr_d  = word_in;
            cnt_d = CNT_TOP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign shifting = (state_q == SHIFT);
  assign last_bit = (cnt_q == '0);

  assign bus.in_ready  = in_ready;
  assign bus.ser_valid = shifting;
  assign bus.ser_bit   = shifting & sr_q[W-1];
  assign bus.ser_odd   = shifting & cnt_q[0];

  qpsk_sipo_word #(
    .W (W)
  ) u_sipo (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shifting),
    .din      (sr_q[W-1]),
    .last     (last_bit),
    .word     (bus.byte_out),
    .done     (bus.byte_valid)
  );

  a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
    bus.byte_valid |=> !bus.byte_valid);

  a_busy_is_shift: assert property (@(posedge clk) disable iff (!rst_n)
    !bus.in_ready |-> shifting);

endmodule

// File: tb/tb_qpsk_bit_combiner.sv
// Directed bench for qpsk_bit_combiner: NSYM=4 and NSYM=1 instances, hand-computed words.
module tb_qpsk_bit_combiner;
  import qpsk_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  qpsk_bit_combiner_if #(.NSYM(4)) bif4 ();
  qpsk_bit_combiner_if #(.NSYM(1)) bif1 ();

  qpsk_bit_combiner #(.NSYM(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bif4));
  qpsk_bit_combiner #(.NSYM(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bif1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle t+1 after acceptance; returns in cycle t+W+1.
  task automatic check_stream(input string tag, input logic [7:0] w,
                              input bit chained, input logic [7:0] prev);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s ser_valid[%0d]", tag, i), bif4.ser_valid, 1);
      chk($sformatf("%s ser_bit[%0d]", tag, i), bif4.ser_bit, w[7-i]);
      chk($sformatf("%s ser_odd[%0d]", tag, i), bif4.ser_odd, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("%s in_ready[%0d]", tag, i), bif4.in_ready, (i == 7) ? 1 : 0);
      if (i == 0 && chained) begin
        chk($sformatf("%s byte_valid[0]", tag), bif4.byte_valid, 1);
        chk($sformatf("%s byte_out[0]", tag), bif4.byte_out, prev);
      end else begin
        chk($sformatf("%s byte_valid[%0d]", tag, i), bif4.byte_valid, 0);
      end
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]            bb;
    logic [NSYM_MAX-1:0]   ev, od;
    logic [2*NSYM_MAX-1:0] il;
    logic [7:0]            il_lo;
    int                    n;
    bit                    seen;

    rst_n          = 1'b0;
    bif4.in_valid  = 1'b0;
    bif4.Sheve     = '0;
    bif4.Shodd     = '0;
    bif1.in_valid  = 1'b0;
    bif1.Sheve     = '0;
    bif1.Shodd     = '0;
    tick();
    tick();

    // Reset state
    chk("rst in_ready", bif4.in_ready, 1);
    chk("rst ser_bit", bif4.ser_bit, 0);
    chk("rst ser_valid", bif4.ser_valid, 0);
    chk("rst ser_odd", bif4.ser_odd, 0);
    chk("rst byte_out", bif4.byte_out, 0);
    chk("rst byte_valid", bif4.byte_valid, 0);
    chk("rst1 in_ready", bif1.in_ready, 1);
    chk("rst1 byte_out", bif1.byte_out, 0);
    rst_n = 1'b1;
    tick();

    // Single word 0x6C
    bif4.Sheve    = 4'b1010;
    bif4.Shodd    = 4'b0110;
    bif4.in_valid = 1'b1;
    chk("t1 in_ready idle", bif4.in_ready, 1);
    tick();
    bif4.in_valid = 1'b0;
    check_stream("t1", 8'h6C, 1'b0, 8'h00);
    chk("t1 byte_valid", bif4.byte_valid, 1);
    chk("t1 byte_out", bif4.byte_out, 8'h6C);
    chk("t1 ser_valid end", bif4.ser_valid, 0);
    chk("t1 in_ready end", bif4.in_ready, 1);
    tick();
    chk("t1 byte_valid pulse", bif4.byte_valid, 0);
    chk("t1 byte_out hold", bif4.byte_out, 8'h6C);

    // Back-to-back 0xFF then 0x00, next word held valid while busy
    bif4.Sheve    = 4'hF;
    bif4.Shodd    = 4'hF;
    bif4.in_valid = 1'b1;
    tick();
    bif4.Sheve = 4'h0;
    bif4.Shodd = 4'h0;
    check_stream("t2a", 8'hFF, 1'b0, 8'h00);
    bif4.in_valid = 1'b0;
    check_stream("t2b", 8'h00, 1'b1, 8'hFF);
    chk("t2 byte_valid", bif4.byte_valid, 1);
    chk("t2 byte_out", bif4.byte_out, 8'h00);
    chk("t2 ser_valid end", bif4.ser_valid, 0);
    tick();

    // Reset in the middle of a word
    bif4.Sheve    = 4'b1010;
    bif4.Shodd    = 4'b0110;
    bif4.in_valid = 1'b1;
    tick();
    bif4.in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("t4 ser_valid before", bif4.ser_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t4 ser_valid", bif4.ser_valid, 0);
    chk("t4 in_ready", bif4.in_ready, 1);
    chk("t4 ser_bit", bif4.ser_bit, 0);
    tick();
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bif4.byte_valid) seen = 1'b1;
      tick();
    end
    chk("t4 no byte_valid", seen, 0);
    chk("t4 byte_out cleared", bif4.byte_out, 0);
    bif4.Sheve    = 4'hC;
    bif4.Shodd    = 4'h3;
    bif4.in_valid = 1'b1;
    tick();
    bif4.in_valid = 1'b0;
    check_stream("t4", 8'h5A, 1'b0, 8'h00);
    chk("t4 byte_valid", bif4.byte_valid, 1);
    chk("t4 byte_out", bif4.byte_out, 8'h5A);
    tick();

    // Loopback over all byte values
    for (int b = 0; b < 256; b++) begin
      bb = b[7:0];
      ev = '0;
      od = '0;
      for (int k = 0; k < 4; k++) begin
        ev[k] = bb[2*k];
        od[k] = bb[2*k+1];
      end
      il    = interleave(ev, od);
      il_lo = il[7:0];
      chk($sformatf("t5 interleave %02h", bb), il_lo, bb);
      bif4.Sheve    = ev[3:0];
      bif4.Shodd    = od[3:0];
      bif4.in_valid = 1'b1;
      n = 0;
      while (!bif4.in_ready && n < 16) begin
        tick();
        n++;
      end
      chk($sformatf("t5 ready wait %02h", bb), (n < 16) ? 1 : 0, 1);
      tick();
      bif4.in_valid = 1'b0;
      n = 0;
      while (!bif4.byte_valid && n < 16) begin
        tick();
        n++;
      end
      chk($sformatf("t5 latency %02h", bb), n, 8);
      chk($sformatf("t5 byte_out %02h", bb), bif4.byte_out, bb);
    end
    tick();

    // NSYM=1 instance
    bif1.Sheve    = 1'b1;
    bif1.Shodd    = 1'b0;
    bif1.in_valid = 1'b1;
    chk("t6 in_ready idle", bif1.in_ready, 1);
    tick();
    bif1.in_valid = 1'b0;
    chk("t6 ser_valid[0]", bif1.ser_valid, 1);
    chk("t6 ser_bit[0]", bif1.ser_bit, 0);
    chk("t6 ser_odd[0]", bif1.ser_odd, 1);
    chk("t6 in_ready[0]", bif1.in_ready, 0);
    tick();
    chk("t6 ser_bit[1]", bif1.ser_bit, 1);
    chk("t6 ser_odd[1]", bif1.ser_odd, 0);
    chk("t6 in_ready[1]", bif1.in_ready, 1);
    chk("t6 byte_valid early", bif1.byte_valid, 0);
    tick();
    chk("t6 byte_valid", bif1.byte_valid, 1);
    chk("t6 byte_out", bif1.byte_out, 2'b01);
    chk("t6 ser_valid end", bif1.ser_valid, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
